// File: rtl/ahb_lite_mem_slave_if.sv
// AHB-Lite bus bundle between one master and the memory responder.
// The master modport also owns hready_in, standing in for the interconnect's HREADY.
interface ahb_lite_mem_slave_if;
   logic        hsel;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [31:0] haddr;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready_in;
   logic        hready_out;
   logic [1:0]  hresp;
   logic [31:0] hrdata;

   modport master (
      output hsel, htrans, hwrite, haddr, hsize, hwdata, hready_in,
      input  hready_out, hresp, hrdata
   );

   modport slave (
      input  hsel, htrans, hwrite, haddr, hsize, hwdata, hready_in,
      output hready_out, hresp, hrdata
   );
endinterface

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite responder backed by a flop memory, with programmable OKAY wait
// states and a two-cycle ERROR response for out-of-window, misaligned or non-word accesses.
module ahb_lite_mem_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 16,
   parameter int          WAIT_CYC  = 0
) (
   input logic                 hclk,
   input logic                 hrest_n,
   ahb_lite_mem_slave_if.slave bus
);

   localparam int          AW        = $clog2(DEPTH);
   localparam int          BW        = AW + 2;
   localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);
   localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t         state_q, state_d;
   logic [2:0]     wcnt_q, wcnt_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic           write_q, write_d;
   logic           err_q, err_d;
   logic           pend_q, pend_d;
   logic [31:0]    mem_q [DEPTH];
   logic [31:0]    mem_d [DEPTH];

   logic [31:0]    offset;
   logic           in_range;
   logic           acc_err;
   logic           ready_int;
   logic           accept;
   logic           complete_ok;

   // Address decode: full 32-bit range compare, so there is no aliasing past the window.
   always_comb begin
      offset    = bus.haddr - BASE_ADDR;
      in_range  = (bus.haddr >= BASE_ADDR) && (offset < WIN_BYTES);
      acc_err   = !in_range || (bus.haddr[1:0] != 2'b00) || (bus.hsize != 3'b010);
      ready_int = (state_q == ST_IDLE) || (state_q == ST_ERR2);
      accept    = ready_int && bus.hsel && bus.htrans[1] && bus.hready_in;
      // pend_q in IDLE means a data phase is finishing this very cycle
      complete_ok = (state_q == ST_IDLE) && pend_q && !err_q;
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      err_d   = err_q;
      pend_d  = pend_q;
      unique case (state_q)
         ST_IDLE, ST_ERR2: begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            err_d   = 1'b0;
            if (accept) begin
               pend_d  = 1'b1;
               addr_d  = offset[BW-1:2];
               write_d = bus.hwrite;
               err_d   = acc_err;
               if (acc_err) begin
                  state_d = ST_ERR1;
               end else if (WAIT_CYC > 0) begin
                  state_d = ST_WAIT;
                  wcnt_d  = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (wcnt_q == 3'd0) begin
               state_d = ST_IDLE;
            end else begin
               wcnt_d = wcnt_q - 3'd1;
            end
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Writes land only on the OKAY completing edge; ERROR phases never touch memory.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (complete_ok && write_q) begin
         mem_d[addr_q] = bus.hwdata;
      end
   end

   always_ff @(posedge hclk or negedge hrest_n) begin
      if (!hrest_n) begin
         state_q <= ST_IDLE;
         wcnt_q  <= 3'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'h0;
         end
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Read data is shown for the whole OKAY read data phase, including wait cycles.
   always_comb begin
      bus.hready_out = ready_int;
      bus.hresp      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
      bus.hrdata     = 32'h0;
      if (pend_q && !write_q && !err_q && ((state_q == ST_IDLE) || (state_q == ST_WAIT))) begin
         bus.hrdata = mem_q[addr_q];
      end
   end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: three instances (different wait counts and base) share one
// stimulus bus; only the active one is selected and its outputs are checked against a transfer model.
module tb_ahb_lite_mem_slave;

   typedef struct packed {
      bit          real_x;
      bit          sel;
      logic [1:0]  trans;
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } xfer_t;

   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h0000_0000;
   localparam logic [31:0] BASE2 = 32'h0000_1000;

   logic        hclk;
   logic        hrest_n;
   logic        hsel;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [31:0] haddr;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   int          active;

   logic        obs_ready;
   logic [1:0]  obs_resp;
   logic [31:0] obs_rdata;

   int          vectors;
   int          miscompares;
   logic [31:0] model_mem [3][16];
   xfer_t       seq_q [$];

   ahb_lite_mem_slave_if bus0 ();
   ahb_lite_mem_slave_if bus1 ();
   ahb_lite_mem_slave_if bus2 ();

   ahb_lite_mem_slave #(.BASE_ADDR(BASE0), .DEPTH(16), .WAIT_CYC(0))
      u_dut0 (.hclk(hclk), .hrest_n(hrest_n), .bus(bus0));
   ahb_lite_mem_slave #(.BASE_ADDR(BASE1), .DEPTH(16), .WAIT_CYC(3))
      u_dut1 (.hclk(hclk), .hrest_n(hrest_n), .bus(bus1));
   ahb_lite_mem_slave #(.BASE_ADDR(BASE2), .DEPTH(16), .WAIT_CYC(2))
      u_dut2 (.hclk(hclk), .hrest_n(hrest_n), .bus(bus2));

   assign bus0.hsel = hsel && (active == 0);
   assign bus1.hsel = hsel && (active == 1);
   assign bus2.hsel = hsel && (active == 2);
   assign bus0.htrans = htrans;  assign bus1.htrans = htrans;  assign bus2.htrans = htrans;
   assign bus0.hwrite = hwrite;  assign bus1.hwrite = hwrite;  assign bus2.hwrite = hwrite;
   assign bus0.haddr  = haddr;   assign bus1.haddr  = haddr;   assign bus2.haddr  = haddr;
   assign bus0.hsize  = hsize;   assign bus1.hsize  = hsize;   assign bus2.hsize  = hsize;
   assign bus0.hwdata = hwdata;  assign bus1.hwdata = hwdata;  assign bus2.hwdata = hwdata;
   assign bus0.hready_in = obs_ready;
   assign bus1.hready_in = obs_ready;
   assign bus2.hready_in = obs_ready;

   always_comb begin
      obs_ready = 1'b1;
      obs_resp  = 2'b00;
      obs_rdata = 32'h0;
      case (active)
         0: begin obs_ready = bus0.hready_out; obs_resp = bus0.hresp; obs_rdata = bus0.hrdata; end
         1: begin obs_ready = bus1.hready_out; obs_resp = bus1.hresp; obs_rdata = bus1.hrdata; end
         2: begin obs_ready = bus2.hready_out; obs_resp = bus2.hresp; obs_rdata = bus2.hrdata; end
         default: ;
      endcase
   end

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   function automatic logic [31:0] base_of(input int d);
      return (d == 2) ? BASE2 : ((d == 1) ? BASE1 : BASE0);
   endfunction

   function automatic int waits_of(input int d);
      return (d == 1) ? 3 : ((d == 2) ? 2 : 0);
   endfunction

   // Error rule: outside the 64-byte window, not word aligned, or not a word transfer.
   function automatic bit is_err(input int d, input logic [31:0] addr, input logic [2:0] size);
      longint a, b;
      a = longint'({32'h0, addr});
      b = longint'({32'h0, base_of(d)});
      return !((a >= b) && (a < b + 64)) || (addr[1:0] != 2'b00) || (size != 3'b010);
   endfunction

   function automatic int word_idx(input int d, input logic [31:0] addr);
      return int'(((addr - base_of(d)) >> 2) & 32'hF);
   endfunction

   function automatic xfer_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata);
      xfer_t x;
      x.real_x = 1'b1;
      x.sel    = 1'b1;
      x.trans  = 2'b10;
      x.wr     = wr;
      x.addr   = addr;
      x.size   = size;
      x.wdata  = wdata;
      return x;
   endfunction

   task automatic applyStimulus_idle();
      hsel   = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
      haddr  = $urandom;
      hsize  = 3'b010;
   endtask

   task automatic do_reset();
      hrest_n = 1'b0;
      applyStimulus_idle();
      hwdata = 32'h0;
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      hrest_n = 1'b1;
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 16; i++)
            model_mem[d][i] = 32'h0;
   endtask

   // Plays seq_q on DUT d as a pipelined master and checks every cycle of every data phase.
   task automatic run_seq(input int d);
      int          ai, di, ph, n, cyc, w, idx;
      bit          derr;
      logic        exp_ready;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      bit          chk_data;
      active = d;
      n = seq_q.size();
      ai = 0; di = -1; ph = 0; cyc = 0; w = waits_of(d);
      while ((ai < n || di >= 0) && cyc < n * 12 + 20) begin
         @(negedge hclk);
         cyc++;
         exp_ready = 1'b1; exp_resp = 2'b00; exp_rdata = 32'h0; chk_data = 1'b1;
         hwdata = $urandom;
         if (di >= 0) begin
            derr = is_err(d, seq_q[di].addr, seq_q[di].size);
            idx  = word_idx(d, seq_q[di].addr);
            if (derr) begin
               exp_ready = (ph == 1);
               exp_resp  = 2'b01;
            end else begin
               exp_ready = (ph == w);
               chk_data  = exp_ready;
               if (exp_ready && !seq_q[di].wr) exp_rdata = model_mem[d][idx];
               if (exp_ready && seq_q[di].wr) begin
                  hwdata = seq_q[di].wdata;
                  model_mem[d][idx] = seq_q[di].wdata;
               end
            end
         end
         vectors++;
         if (obs_ready !== exp_ready) begin
            miscompares++;
            $display("[TB] FAIL hready dut%0d cyc%0d: got %b expected %b", d, cyc, obs_ready, exp_ready);
         end
         vectors++;
         if (obs_resp !== exp_resp) begin
            miscompares++;
            $display("[TB] FAIL hresp dut%0d cyc%0d: got %b expected %b", d, cyc, obs_resp, exp_resp);
         end
         if (chk_data) begin
            vectors++;
            if (obs_rdata !== exp_rdata) begin
               miscompares++;
               $display("[TB] FAIL hrdata dut%0d cyc%0d: got %h expected %h", d, cyc, obs_rdata, exp_rdata);
            end
         end
         if (ai < n) begin
            hsel   = seq_q[ai].sel;
            htrans = seq_q[ai].trans;
            hwrite = seq_q[ai].wr;
            haddr  = seq_q[ai].addr;
            hsize  = seq_q[ai].size;
         end else begin
            applyStimulus_idle();
         end
         @(posedge hclk);
         #1;
         if (di >= 0) begin
            if (exp_ready) di = -1;
            else ph++;
         end
         if (ai < n) begin
            if (!seq_q[ai].real_x) begin
               ai++;
            end else if (exp_ready) begin
               di = ai; ph = 0; ai++;
            end
         end
      end
      vectors++;
      if (ai < n || di >= 0) begin
         miscompares++;
         $display("[TB] FAIL timeout dut%0d: issued %0d of %0d, pending %0d", d, ai, n, di);
      end
      seq_q.delete();
      applyStimulus_idle();
   endtask

   task automatic test_reset();
      do_reset();
      for (int d = 0; d < 3; d++) begin
         active = d;
         #1;
         vectors++;
         if (obs_ready !== 1'b1 || obs_resp !== 2'b00 || obs_rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs dut%0d: got %b/%b/%h expected 1/00/00000000",
                     d, obs_ready, obs_resp, obs_rdata);
         end
      end
   endtask

   task automatic test_write_read();
      seq_q.push_back(mk(1'b1, BASE0 + 32'h8, 3'b010, 32'hDEAD_BEEF));
      seq_q.push_back(mk(1'b0, BASE0 + 32'h8, 3'b010, 32'h0));
      run_seq(0);
      vectors++;
      if (model_mem[0][2] !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("[TB] FAIL model_word2: got %h expected deadbeef", model_mem[0][2]);
      end
   endtask

   task automatic test_wait_read();
      seq_q.push_back(mk(1'b0, BASE1, 3'b010, 32'h0));
      run_seq(1);
   endtask

   task automatic test_errors();
      for (int d = 0; d < 3; d++) begin
         seq_q.push_back(mk(1'b1, base_of(d) + 32'd64, 3'b010, 32'h1234_5678));
         seq_q.push_back(mk(1'b0, base_of(d), 3'b000, 32'h0));
         seq_q.push_back(mk(1'b1, base_of(d) + 32'h2, 3'b010, 32'hCAFE_F00D));
         seq_q.push_back(mk(1'b1, base_of(d) - 32'd4, 3'b010, 32'h5555_AAAA));
         seq_q.push_back(mk(1'b0, base_of(d), 3'b010, 32'h0));
         run_seq(d);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         seq_q.push_back(mk(1'b1, BASE0 + 32'(i * 4), 3'b010, 32'(i + 1)));
      for (int i = 0; i < 4; i++)
         seq_q.push_back(mk(1'b0, BASE0 + 32'(i * 4), 3'b010, 32'h0));
      run_seq(0);
   endtask

   task automatic test_random();
      xfer_t x;
      logic [31:0] b;
      for (int d = 0; d < 3; d++) begin
         b = base_of(d);
         for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) begin
               x = mk(1'($urandom), $urandom, 3'b010, $urandom);
               x.real_x = 1'b0;
               if ($urandom_range(0, 1) == 0) begin
                  x.sel = 1'b0;
               end else begin
                  x.trans = 2'($urandom_range(0, 1));
               end
            end else begin
               x = mk(1'($urandom), b + 32'(4 * $urandom_range(0, 15)), 3'b010, $urandom);
               x.trans = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
               case ($urandom_range(0, 9))
                  0: x.addr = b + 32'd64 + 32'(4 * $urandom_range(0, 15));
                  1: x.addr = x.addr + 32'($urandom_range(1, 3));
                  2: x.size = 3'($urandom_range(0, 1));
                  3: x.addr = $urandom;
                  default: ;
               endcase
            end
            seq_q.push_back(x);
         end
         run_seq(d);
      end
   endtask

   task automatic test_reset_midwrite();
      active = 2;
      @(negedge hclk);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = BASE2 + 32'h4; hsize = 3'b010;
      @(posedge hclk);
      #1;
      applyStimulus_idle();
      hwdata = 32'hA5A5_5A5A;
      @(negedge hclk);
      vectors++;
      if (obs_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midwrite_wait: got %b expected 0", obs_ready);
      end
      #2;
      hrest_n = 1'b0;
      #1;
      vectors++;
      if (obs_ready !== 1'b1 || obs_resp !== 2'b00 || obs_rdata !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL async_reset_outputs: got %b/%b/%h expected 1/00/00000000",
                  obs_ready, obs_resp, obs_rdata);
      end
      @(posedge hclk);
      @(negedge hclk);
      hrest_n = 1'b1;
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 16; i++)
            model_mem[d][i] = 32'h0;
      seq_q.push_back(mk(1'b0, BASE2 + 32'h4, 3'b010, 32'h0));
      run_seq(2);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      active = 0;
      hwdata = 32'h0;
      test_reset();
      test_write_read();
      test_wait_read();
      test_errors();
      test_back_to_back();
      test_random();
      test_reset_midwrite();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
